truth_table_scanner: RTL and testbench
======================================

# truth_table_scanner

Sequential scanner that sits on both sides of the 4-input function block F: it drives all 16 input codes onto F's `a`,`b`,`c`,`d` inputs in ascending order and samples F's output `o` for each code. It assembles a 16-bit truth table and, optionally, a minterm count. It replaces the hand-written exhaustive stimulus sequence with a self-running hardware sweep, so F can be characterised in-system.

## Interface

Parameters:
- `SETTLE`, default 2: cycles each code is held before sampling. Legal range is 1..15.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `start`  in  1  request a sweep; accepted only in IDLE.
- `f_in`  in  1  F output `o`.
- `a`  out  1  code bit 3 (MSB) to F.
- `b`  out  1  code bit 2 to F.
- `c`  out  1  code bit 1 to F.
- `d`  out  1  code bit 0 (LSB) to F.
- `busy`  out  1  high in SETTLE and SAMPLE.
- `done`  out  1  single-cycle pulse when the table is complete.
- `table_out`  out  16  bit i = F(i), where i = {a,b,c,d}.
- `ones`  out  5  number of 1s in `table_out` (range 0..16); see Configuration.

## Operation

States:
- IDLE
- SETTLE
- SAMPLE
- DONE

Internal registers:
- `idx[3:0]`: current code.
- `cnt[3:0]`: settle counter.

Reset values, applied on the first rising edge with `rst_n`=0, from any state:
- state = IDLE
- `idx` = 0, `cnt` = 0
- `a`/`b`/`c`/`d` = 0
- `busy` = 0, `done` = 0
- `table_out` = 0, `ones` = 0

Transitions:
- IDLE, `start`=1 → SETTLE. Same edge: `idx`=0, `cnt`=0, `table_out`=0, `ones`=0, `{a,b,c,d}`=0.
- IDLE, `start`=0 → stay in IDLE. Outputs hold, including the last `table_out`/`ones`.
- SETTLE → `cnt` increments each cycle. When `cnt`==SETTLE-1, go to SAMPLE.
- SAMPLE:
  - On the leaving edge: `table_out[idx]` <= `f_in`; `ones` <= `ones` + `f_in`.
  - If `idx`==15 → DONE and `{a,b,c,d}` <= 0.
  - Otherwise `idx` <= `idx`+1, `{a,b,c,d}` <= `idx`+1, `cnt` <= 0, go to SETTLE.
- DONE → IDLE after one cycle. `done`=1 only while in DONE.

Rules:
- `{a,b,c,d}` always equals `idx` during SETTLE and SAMPLE, and is stable for SETTLE+1 cycles per code.
- `start` is ignored in SETTLE, SAMPLE and DONE; no queuing.
- `idx` never wraps. The sweep terminates at 15.
- Reset mid-sweep aborts immediately. The partial table is discarded (`table_out`=0).
- `f_in` is sampled only on the edge leaving SAMPLE. Glitches during SETTLE have no effect.

## Timing

- Start accepted at edge k. Code i is driven during cycles k+i·(SETTLE+1) … k+(i+1)·(SETTLE+1)−1.
- `f_in` for code i is captured at edge k+(i+1)·(SETTLE+1).
- DONE is entered at edge k+16·(SETTLE+1). `done` is high for that one cycle only.
- For SETTLE=2, `done` is high 48 cycles after the start edge.
- `busy` is high from edge k to edge k+16·(SETTLE+1).
- `table_out` and `ones` are final and valid when `done`=1. They stay valid until the next accepted `start` or reset.
- A new `start` may be accepted in the cycle after DONE.

## Configuration

- Macro: `TRUTH_TABLE_SCANNER_ONES_EN`.
- Defined:
  - The `ones` accumulator is built.
  - It increments by `f_in` at each SAMPLE exit and clears on start and reset.
- Undefined:
  - No accumulator logic.
  - `ones` is tied to 5'd0.
  - All other behaviour is identical.

## Test plan

- Reset, then `start` with bench model `f_in`=a^b^c^d, SETTLE=2 → `done` pulse exactly 48 cycles after start; `table_out`=16'h6996; `ones`=8 (0 when the macro is undefined).
- Bench model `f_in`=d → `table_out`=16'hAAAA, `ones`=8. Model `f_in`=0 → `table_out`=16'h0000, `ones`=0. Model `f_in`=1 → `table_out`=16'hFFFF, `ones`=16.
- Monitor `{a,b,c,d}` during the sweep → sequence 0..15, each value held exactly 3 cycles, then 0 at DONE.
- Pulse `start` mid-sweep (code 7) and at DONE → ignored. The result equals an uninterrupted sweep, and a single `done` pulse occurs.
- Assert `rst_n`=0 at code 9 for one cycle → next cycle all outputs are 0 and state is IDLE. A following `start` runs a full 48-cycle sweep.
- Glitch `f_in` only during SETTLE cycles (held 0 in SAMPLE) → `table_out`=16'h0000.

Source files
------------

// File: rtl/truth_table_scanner.sv
// Self-running exhaustive sweep of a 4-input function block: drives codes 0..15, samples f_in per code.
// Optional minterm counter on `ones` is built when TRUTH_TABLE_SCANNER_ONES_EN is defined.
module truth_table_scanner #(
  parameter int unsigned SETTLE = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        f_in,
  output logic        a,
  output logic        b,
  output logic        c,
  output logic        d,
  output logic        busy,
  output logic        done,
  output logic [15:0] table_out,
  output logic [4:0]  ones
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
  } state_e;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  state_e      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  code_q, code_d;
  logic [15:0] table_q, table_d;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    table_d = table_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SETTLE;
          idx_d   = '0;
          cnt_d   = '0;
          code_d  = '0;
          table_d = '0;
        end
      end
      S_SETTLE: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == SETTLE_LAST) state_d = S_SAMPLE;
      end
      S_SAMPLE: begin
        table_d[idx_q] = f_in;
        if (idx_q == 4'hF) begin
          state_d = S_DONE;
          code_d  = '0;
        end else begin
          state_d = S_SETTLE;
          idx_d   = idx_q + 4'd1;
          code_d  = idx_q + 4'd1;
          cnt_d   = '0;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      code_q  <= '0;
      table_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      table_q <= table_d;
    end
  end

`ifdef TRUTH_TABLE_SCANNER_ONES_EN
  logic [4:0] ones_q, ones_d;

  always_comb begin
    ones_d = ones_q;
    if (state_q == S_IDLE && start)
      ones_d = '0;
    else if (state_q == S_SAMPLE)
      ones_d = ones_q + {4'b0000, f_in};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) ones_q <= '0;
    else        ones_q <= ones_d;
  end

  assign ones = ones_q;
`else
  assign ones = '0;
`endif

  assign {a, b, c, d} = code_q;
  assign busy         = (state_q == S_SETTLE) || (state_q == S_SAMPLE);
  assign done         = (state_q == S_DONE);
  assign table_out    = table_q;

endmodule

// File: tb/tb_truth_table_scanner.sv
// Directed bench for truth_table_scanner: timeline model of the sweep checked every cycle,
// plus literal expectations for the tables, counts and latencies.
module tb_truth_table_scanner;

  localparam int unsigned S = 2;
  localparam int unsigned PER = S + 1;
  localparam int unsigned SWEEP = 16 * PER;

  typedef enum int {M_PAR, M_D, M_ZERO, M_ONE, M_GLITCH} mode_e;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        f_in;
  logic        a, b, c, d, busy, done;
  logic [15:0] table_out;
  logic [4:0]  ones;

  mode_e mode = M_PAR;
  logic  glitch = 1'b0;

  int n_vec = 0;
  int n_err = 0;
  int n_done = 0;
  bit chk_en = 1'b0;

  // High-level model: position in the sweep timeline and the table gathered so far.
  bit          m_active = 1'b0;
  bit          m_in_done = 1'b0;
  int          m_t = 0;
  logic [15:0] m_table = '0;

  truth_table_scanner #(.SETTLE(S)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .f_in(f_in),
    .a(a), .b(b), .c(c), .d(d), .busy(busy), .done(done),
    .table_out(table_out), .ones(ones)
  );

  always #5 clk = ~clk;

  function automatic logic fmodel(input mode_e m, input int code);
    logic [3:0] v;
    v = 4'(code);
    case (m)
      M_PAR:   return ^v;
      M_D:     return v[0];
      M_ZERO:  return 1'b0;
      M_ONE:   return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  always_comb begin
    case (mode)
      M_PAR:   f_in = a ^ b ^ c ^ d;
      M_D:     f_in = d;
      M_ZERO:  f_in = 1'b0;
      M_ONE:   f_in = 1'b1;
      default: f_in = glitch;
    endcase
  end

  always @(negedge clk) begin
    if (m_active && (m_t % PER != S)) glitch = 1'($urandom_range(0, 1));
    else                              glitch = 1'b0;
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      m_active = 1'b0; m_in_done = 1'b0; m_t = 0; m_table = '0;
    end else if (m_active) begin
      m_t = m_t + 1;
      if (m_t % PER == 0) m_table[4'(m_t / PER - 1)] = fmodel(mode, m_t / PER - 1);
      if (m_t == SWEEP) begin
        m_active = 1'b0; m_in_done = 1'b1;
      end
    end else if (m_in_done) begin
      m_in_done = 1'b0;
    end else if (start) begin
      m_active = 1'b1; m_t = 0; m_table = '0;
    end
  end

  always @(negedge clk) begin
    logic [3:0] e_code;
    logic [4:0] e_ones;
    if (chk_en) begin
      e_code = m_active ? 4'(m_t / PER) : 4'd0;
`ifdef TRUTH_TABLE_SCANNER_ONES_EN
      e_ones = 5'($countones(m_table));
`else
      e_ones = 5'd0;
`endif
      n_vec++;
      if ({a, b, c, d} !== e_code || busy !== m_active || done !== m_in_done ||
          table_out !== m_table || ones !== e_ones) begin
        n_err++;
        $display("FAIL cycle t=%0d: got abcd=%h busy=%b done=%b table=%h ones=%0d, expected abcd=%h busy=%b done=%b table=%h ones=%0d",
                 m_t, {a, b, c, d}, busy, done, table_out, ones,
                 e_code, m_active, m_in_done, m_table, e_ones);
      end
      if (done === 1'b1) n_done++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Start a sweep, optionally pulse start once while code pulse_code is driven; returns edges to done.
  task automatic sweep(input int pulse_code, output int lat);
    bit pulsed;
    pulsed = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < 200) begin
      if (!pulsed && busy === 1'b1 && int'({a, b, c, d}) == pulse_code) begin
        start = 1'b1; pulsed = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
  endtask

  task automatic check_result(input string name, input logic [15:0] exp_tab, input int exp_pop);
    int lat;
    sweep(-1, lat);
    chk({name, "_latency"}, 32'(lat), 32'd48);
    chk({name, "_table"}, 32'(table_out), 32'(exp_tab));
    chk({name, "_model"}, 32'(m_table), 32'(exp_tab));
`ifdef TRUTH_TABLE_SCANNER_ONES_EN
    chk({name, "_ones"}, 32'(ones), 32'(exp_pop));
`else
    chk({name, "_ones"}, 32'(ones), 32'd0);
    if (exp_pop < 0) $display("unexpected negative population");
`endif
  endtask

  initial begin
    int lat;
    int done_before;
    int guard;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    chk("reset_table", 32'(table_out), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    mode = M_PAR;  check_result("parity", 16'h6996, 8);
    mode = M_D;    check_result("d_only", 16'hAAAA, 8);
    mode = M_ZERO; check_result("zero", 16'h0000, 0);
    mode = M_ONE;  check_result("one", 16'hFFFF, 16);
    repeat (2) @(negedge clk);
    chk("hold_after_done", 32'(table_out), 32'hFFFF);

    // start pulses during code 7 and during DONE must be ignored
    mode = M_PAR;
    done_before = n_done;
    sweep(7, lat);
    chk("interrupt_latency", 32'(lat), 32'd48);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    chk("interrupt_table", 32'(table_out), 32'h6996);
    chk("interrupt_done_pulses", 32'(n_done - done_before), 32'd1);
    chk("interrupt_no_restart", 32'(busy), 32'd0);

    // reset mid-sweep at code 9
    mode = M_ONE;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    guard = 0;
    while (!(busy === 1'b1 && {a, b, c, d} === 4'd9) && guard < 200) begin
      @(negedge clk); guard++;
    end
    chk("reached_code9", 32'({a, b, c, d}), 32'd9);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_table", 32'(table_out), 32'd0);
    chk("abort_ones", 32'(ones), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_code", 32'({a, b, c, d}), 32'd0);
    @(negedge clk);
    mode = M_PAR;  check_result("after_abort", 16'h6996, 8);

    mode = M_GLITCH; check_result("glitch", 16'h0000, 0);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
